pe_drain_arbiter: RTL and testbench
===================================

Name: pe_drain_arbiter

Overview:
- Drains the per-PE output psum FIFOs of an N_PE-wide PE array onto one shared output stream.
- Round-robin arbitration with valid/ready handshake; every word carries the index of its source PE.
- Counts words drained per PE in a frame and pulses frame_done_o once every PE has delivered its quota.
- Sits between the PE array and the psum writeback / accumulation buffer.

Parameters:
N_PE, 4, number of PEs served; 2..16
PSUM_WIDTH, 16, psum width per output element
DW, 3*6*PSUM_WIDTH, PE FIFO word width (3 rows x 6 columns of psums)
CNT_W, 16, width of per-PE word counters and frame_words_i

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse: latch frame_words_i, clear counters, begin frame
frame_words_i  in  CNT_W  words each PE delivers in this frame
pe_fifo_empty_i  in  N_PE  per-PE FIFO empty
pe_fifo_full_i  in  N_PE  per-PE FIFO full
pe_fifo_dout_i  in  N_PE*DW  per-PE FIFO read data; PE k at bits [k*DW +: DW]
pe_fifo_rd_en_o  out  N_PE  per-PE FIFO read enable, one-hot or zero
out_valid_o  out  1  output word valid
out_ready_i  in  1  downstream accepts the word
out_data_o  out  DW  drained word
out_pe_id_o  out  $clog2(N_PE)  source PE index of out_data_o
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse: all PEs reached their quota

Behaviour:
- Reset: all outputs 0, FSM = IDLE, rr pointer = 0, counters = 0.
- FSM states:
  - IDLE: wait for start_i.
  - ARB: select a PE.
  - FETCH: wait one cycle for FIFO read data.
  - SEND: present word downstream.
  - DONE: pulse frame_done_o.
- IDLE -> ARB on start_i. Same edge: quota := frame_words_i, all cnt[k] := 0, rr := 0, busy_o := 1.
- Eligibility: PE k is eligible when pe_fifo_empty_i[k] = 0 and cnt[k] < quota.
- ARB:
  - All PEs at quota -> DONE.
  - Else if any PE eligible: grant the first eligible index at or after rr, wrapping modulo N_PE.
  - Same cycle: pe_fifo_rd_en_o[g] = 1 for exactly one cycle; register g; rr := (g+1) mod N_PE; -> FETCH.
  - Else (none eligible): stay in ARB.
- FETCH:
  - FIFO read latency is exactly 1 cycle.
  - Capture pe_fifo_dout_i slice g into out_data_o; out_pe_id_o := g; cnt[g] += 1; out_valid_o := 1; -> SEND.
- SEND:
  - out_data_o and out_pe_id_o are held stable while out_valid_o = 1 and out_ready_i = 0.
  - On out_valid_o & out_ready_i: out_valid_o := 0; -> ARB.
- Throughput: at most one word per 3 cycles.
- pe_fifo_rd_en_o is only ever asserted in ARB, so a PE FIFO is never read while the output register is occupied.
- DONE: frame_done_o = 1 for exactly one cycle; busy_o := 0; -> IDLE.
- frame_words_i = 0: first ARB finds every PE at quota; frame_done_o fires 2 cycles after start_i. No reads issued.
- A PE at quota that is still non-empty is never read; its words remain for the next frame.
- start_i is ignored outside IDLE.
- Reset asserted mid-frame: immediate return to reset values; a word in flight is lost, with no read retry.
- Counters saturate at quota; no wrap.

Optional Feature:
- Macro: PE_DRAIN_FULL_PRIO_EN.
- Defined: in ARB, if any eligible PE has pe_fifo_full_i = 1, grant the first such PE at or after rr (wrapping), overriding plain round-robin. rr update is unchanged (g+1). Prevents PE stall on a full FIFO.
- Undefined: pe_fifo_full_i is ignored; pure round-robin.

Test Plan:
- N_PE = 4, quota 2, all FIFOs non-empty, out_ready_i = 1 -> grant order 0,1,2,3,0,1,2,3; 8 words with matching out_pe_id_o; frame_done_o pulses once; busy_o falls the same cycle.
- Only PE2 non-empty, quota 1 -> one read of PE2 only; arbiter waits in ARB until the other FIFOs become non-empty and deliver; then frame_done_o.
- out_ready_i held 0 for 5 cycles in SEND -> out_data_o/out_pe_id_o stable; no pe_fifo_rd_en_o during the stall; resumes on ready.
- frame_words_i = 0 -> no rd_en; frame_done_o exactly 2 cycles after start_i.
- Reset pulsed while in SEND -> out_valid_o = 0, busy_o = 0, counters cleared; a new start_i runs a full frame correctly.
- PE_DRAIN_FULL_PRIO_EN defined, rr = 0, PE3 full, PE0/PE1 non-empty -> PE3 granted first, then 0, 1.

Source files
------------

// File: rtl/pe_drain_arbiter.sv
// Round-robin drain of per-PE psum FIFOs onto one valid/ready stream, with per-frame quotas.
// Optional macro PE_DRAIN_FULL_PRIO_EN: eligible PEs with a full FIFO win over plain round-robin.
module pe_drain_arbiter #(
  parameter int N_PE       = 4,
  parameter int PSUM_WIDTH = 16,
  parameter int DW         = 3*6*PSUM_WIDTH,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     frame_words_i,
  input  logic [N_PE-1:0]      pe_fifo_empty_i,
  input  logic [N_PE-1:0]      pe_fifo_full_i,
  input  logic [N_PE*DW-1:0]   pe_fifo_dout_i,
  output logic [N_PE-1:0]      pe_fifo_rd_en_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_data_o,
  output logic [ID_W-1:0]      out_pe_id_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [2:0]           dbg_state_o
);

  // Output handshake: a word transfers on a cycle where out_valid_o and out_ready_i are both 1;
  // while out_valid_o is high and out_ready_i low, out_data_o/out_pe_id_o hold their value.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_quota;
  logic [CNT_W-1:0] r_cnt [N_PE];
  logic [ID_W-1:0]  r_rr;
  logic [ID_W-1:0]  r_gnt;
  logic             r_valid;
  logic [DW-1:0]    r_data;
  logic [ID_W-1:0]  r_pe_id;
  logic             r_busy;

  logic [N_PE-1:0]  w_at_quota;
  logic [N_PE-1:0]  w_elig;
  logic [N_PE-1:0]  w_cand;
  logic             w_all_done;
  logic             w_found;
  logic [ID_W-1:0]  w_gnt;
  logic             w_take;
  int               w_idx;

  always_comb begin
    w_at_quota = '0;
    w_elig     = '0;
    for (int k = 0; k < N_PE; k++) begin
      w_at_quota[k] = (r_cnt[k] >= r_quota);
      w_elig[k]     = !pe_fifo_empty_i[k] && !w_at_quota[k];
    end
  end

  assign w_all_done = &w_at_quota;

`ifdef PE_DRAIN_FULL_PRIO_EN
  logic [N_PE-1:0] w_prio;
  assign w_prio = w_elig & pe_fifo_full_i;
  assign w_cand = (|w_prio) ? w_prio : w_elig;
`else
  logic w_unused_full;
  assign w_unused_full = ^pe_fifo_full_i;
  assign w_cand        = w_elig;
`endif

  // Scan candidates starting at the rr pointer and wrapping; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int i = 0; i < N_PE; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= N_PE) w_idx = w_idx - N_PE;
      if (!w_found && w_cand[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_take = (r_state == S_ARB) && !w_all_done && w_found;

  always_comb begin
    pe_fifo_rd_en_o = '0;
    for (int k = 0; k < N_PE; k++) begin
      pe_fifo_rd_en_o[k] = w_take && (w_gnt == ID_W'(k));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_ARB;
      S_ARB: begin
        if (w_all_done)   w_next = S_DONE;
        else if (w_found) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (out_ready_i) w_next = S_ARB;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quota <= '0;
      for (int k = 0; k < N_PE; k++) r_cnt[k] <= '0;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pe_id <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_quota <= frame_words_i;
            for (int k = 0; k < N_PE; k++) r_cnt[k] <= '0;
            r_rr    <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_take) begin
            r_gnt <= w_gnt;
            r_rr  <= (w_gnt == ID_W'(N_PE-1)) ? '0 : w_gnt + ID_W'(1);
          end else if (w_all_done) begin
            r_busy <= 1'b0;
          end
        end
        S_FETCH: begin
          // Read data arrives exactly one cycle after the rd_en pulse.
          r_data  <= pe_fifo_dout_i[int'(r_gnt)*DW +: DW];
          r_pe_id <= r_gnt;
          r_valid <= 1'b1;
          if (r_cnt[r_gnt] < r_quota) r_cnt[r_gnt] <= r_cnt[r_gnt] + CNT_W'(1);
        end
        S_SEND: begin
          if (out_ready_i) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o  = r_valid;
  assign out_data_o   = r_data;
  assign out_pe_id_o  = r_pe_id;
  assign busy_o       = r_busy;
  assign frame_done_o = (r_state == S_DONE);
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_pe_drain_arbiter.sv
// Self-checking bench for pe_drain_arbiter: bench-owned PE FIFOs, transaction-level model, per-cycle compare.
module tb_pe_drain_arbiter;
  localparam int N_PE       = 4;
  localparam int PSUM_WIDTH = 16;
  localparam int DW         = 3*6*PSUM_WIDTH;
  localparam int CNT_W      = 16;
  localparam int ID_W       = 2;
  localparam int DEPTH      = 4;

  typedef logic [DW-1:0] word_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic [CNT_W-1:0]   frame_words_i = '0;
  logic [N_PE-1:0]    pe_fifo_empty_i = '1;
  logic [N_PE-1:0]    pe_fifo_full_i = '0;
  logic [N_PE*DW-1:0] pe_fifo_dout_i = '0;
  logic [N_PE-1:0]    pe_fifo_rd_en_o;
  logic               out_valid_o;
  logic               out_ready_i = 1'b0;
  logic [DW-1:0]      out_data_o;
  logic [ID_W-1:0]    out_pe_id_o;
  logic               busy_o;
  logic               frame_done_o;
  logic [2:0]         dbg_state_o;

  pe_drain_arbiter #(
    .N_PE(N_PE), .PSUM_WIDTH(PSUM_WIDTH), .DW(DW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .frame_words_i(frame_words_i),
    .pe_fifo_empty_i(pe_fifo_empty_i), .pe_fifo_full_i(pe_fifo_full_i),
    .pe_fifo_dout_i(pe_fifo_dout_i), .pe_fifo_rd_en_o(pe_fifo_rd_en_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_pe_id_o(out_pe_id_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- environment (PE FIFOs) ----------------
  word_t env_q [N_PE][$];
  word_t env_dout [N_PE];
  int    push_pct  = 0;
  int    ready_pct = 100;

  // ---------------- next-cycle controls ----------------
  bit               nxt_start = 0;
  logic [CNT_W-1:0] nxt_fw = '0;
  bit               nxt_rst = 1;

  // ---------------- model + scoreboard ----------------
  bit   m_busy, m_arb, m_done, m_valid;
  int   m_fetch = -1;
  int   m_rr, m_quota;
  int   m_cnt [N_PE];
  logic [ID_W+DW-1:0] exp_q[$];
  int   grant_log[$];
  int   done_cnt, cyc, last_done_cyc, start_cyc;
  int   n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic bit elig(input int k);
    return (env_q[k].size() > 0) && (m_cnt[k] < m_quota);
  endfunction

  // Smallest round-robin distance from rr among eligible PEs (full ones first when enabled).
  function automatic int pick();
    int best = -1;
    int bestd = N_PE;
    bit any_full = 0;
`ifdef PE_DRAIN_FULL_PRIO_EN
    for (int k = 0; k < N_PE; k++) if (elig(k) && env_q[k].size() >= DEPTH) any_full = 1;
`endif
    for (int k = 0; k < N_PE; k++) begin
      if (elig(k) && (!any_full || env_q[k].size() >= DEPTH)) begin
        int d = (k - m_rr + N_PE) % N_PE;
        if (d < bestd) begin bestd = d; best = k; end
      end
    end
    return best;
  endfunction

  function automatic logic [63:0] pack_log();
    logic [63:0] p = '0;
    foreach (grant_log[i]) p = {p[59:0], 4'(grant_log[i])};
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_arb = 0; m_done = 0; m_valid = 0; m_fetch = -1;
    m_rr = 0; m_quota = 0;
    for (int k = 0; k < N_PE; k++) m_cnt[k] = 0;
    exp_q.delete();
  endtask

  // ---------------- one clock cycle: drive, compare, advance ----------------
  task automatic step();
    logic [N_PE-1:0] exp_rd;
    logic [ID_W+DW-1:0] head;
    bit all_q, cur_start, n_arb, n_done;
    int g, n_fetch;
    @(negedge clk);
    rst_n         = !nxt_rst;
    cur_start     = nxt_start;
    start_i       = nxt_start;
    frame_words_i = nxt_fw;
    nxt_start     = 0;
    out_ready_i   = ($urandom_range(99) < ready_pct);
    for (int k = 0; k < N_PE; k++) begin
      pe_fifo_empty_i[k] = (env_q[k].size() == 0);
      pe_fifo_full_i[k]  = (env_q[k].size() >= DEPTH);
      pe_fifo_dout_i[k*DW +: DW] = env_dout[k];
    end
    if (nxt_rst) model_reset();
    #1;
    all_q = 1;
    for (int k = 0; k < N_PE; k++) if (m_cnt[k] < m_quota) all_q = 0;
    g = pick();
    exp_rd = '0;
    if (m_arb && !all_q && g >= 0) exp_rd[g] = 1'b1;
    chk("rd_en", pe_fifo_rd_en_o, exp_rd);
    chk("out_valid", out_valid_o, m_valid);
    chk("busy", busy_o, m_busy);
    chk("frame_done", frame_done_o, m_done);
    if (m_valid && exp_q.size() > 0) begin
      head = exp_q[0];
      chk("out_data", out_data_o, head[DW-1:0]);
      chk("out_pe_id", out_pe_id_o, head[ID_W+DW-1:DW]);
    end
    if (nxt_rst) begin
      chk("rst_data", out_data_o, 0);
      chk("rst_pe_id", out_pe_id_o, 0);
      chk("rst_state", dbg_state_o, 0);
    end
    if (frame_done_o) begin done_cnt++; last_done_cyc = cyc; end
    if (!nxt_rst) begin
      n_arb = 0; n_fetch = -1; n_done = 0;
      if (!m_busy && !m_done && cur_start) begin
        m_quota = int'(nxt_fw); m_rr = 0; m_busy = 1; n_arb = 1;
        for (int k = 0; k < N_PE; k++) m_cnt[k] = 0;
      end
      if (m_arb) begin
        if (all_q) begin n_done = 1; m_busy = 0; end
        else if (g >= 0) begin
          n_fetch = g;
          m_rr = (g + 1) % N_PE;
          exp_q.push_back({ID_W'(g), env_q[g][0]});
          grant_log.push_back(g);
        end else n_arb = 1;
      end
      if (m_fetch >= 0) begin
        if (m_cnt[m_fetch] < m_quota) m_cnt[m_fetch]++;
        m_valid = 1;
      end else if (m_valid && out_ready_i) begin
        m_valid = 0; n_arb = 1;
        void'(exp_q.pop_front());
      end
      m_arb = n_arb; m_fetch = n_fetch; m_done = n_done;
    end
    for (int k = 0; k < N_PE; k++) begin
      if (pe_fifo_rd_en_o[k]) env_dout[k] = (env_q[k].size() > 0) ? env_q[k].pop_front() : rand_word();
      if (env_q[k].size() < DEPTH && $urandom_range(99) < push_pct) env_q[k].push_back(rand_word());
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    do begin step(); i++; end while ((m_busy || m_done || m_arb) && i < bound);
    if (m_busy || m_done || m_arb) begin
      n_checks++; n_err++;
      $display("FAIL timeout: frame still open after %0d cycles", bound);
    end
    step();
  endtask

  task automatic flush_env();
    for (int k = 0; k < N_PE; k++) begin env_q[k].delete(); env_dout[k] = rand_word(); end
  endtask

  task automatic fill(input int k, input int n);
    for (int j = 0; j < n; j++) env_q[k].push_back(rand_word());
  endtask

  task automatic begin_frame(input int fw);
    grant_log.delete(); done_cnt = 0;
    nxt_start = 1; nxt_fw = CNT_W'(fw);
    start_cyc = cyc;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    flush_env();
    model_reset();
    nxt_rst = 1;
    run(3);
    nxt_rst = 0;
    run(2);

    // All FIFOs loaded, quota 2, always ready.
    flush_env(); for (int k = 0; k < N_PE; k++) fill(k, 2);
    push_pct = 0; ready_pct = 100;
    begin_frame(2); wait_idle(200);
    chk("s1_order", pack_log(), 64'h0123_0123);
    chk("s1_done_cnt", done_cnt, 1);

    // Only PE2 has data; others arrive later.
    flush_env(); fill(2, 1);
    begin_frame(1); run(20);
    chk("s2_first", pack_log(), 64'h2);
    fill(0, 1); fill(1, 1); fill(3, 1);
    wait_idle(200);
    chk("s2_order", pack_log(), 64'h2301);
    chk("s2_done_cnt", done_cnt, 1);

    // Downstream stall of 5 cycles while a word is held.
    flush_env(); for (int k = 0; k < N_PE; k++) fill(k, 1);
    ready_pct = 0;
    begin_frame(1); step();
    for (int i = 0; i < 10 && !m_valid; i++) step();
    run(5);
    ready_pct = 100;
    wait_idle(200);
    chk("s3_order", pack_log(), 64'h0123);
    chk("s3_done_cnt", done_cnt, 1);

    // Zero quota: no reads, done two cycles after start.
    flush_env(); for (int k = 0; k < N_PE; k++) fill(k, 1);
    begin_frame(0); wait_idle(20);
    chk("s4_latency", last_done_cyc - start_cyc, 2);
    chk("s4_no_reads", grant_log.size(), 0);
    chk("s4_done_cnt", done_cnt, 1);

    // Reset while a word is waiting in SEND, then a clean frame.
    flush_env(); for (int k = 0; k < N_PE; k++) fill(k, 2);
    ready_pct = 0;
    begin_frame(2); step();
    for (int i = 0; i < 10 && !m_valid; i++) step();
    run(2);
    nxt_rst = 1; run(2);
    nxt_rst = 0; step();
    flush_env(); for (int k = 0; k < N_PE; k++) fill(k, 2);
    ready_pct = 100;
    begin_frame(2); wait_idle(200);
    chk("s5_order", pack_log(), 64'h0123_0123);
    chk("s5_done_cnt", done_cnt, 1);

    // Randomised frames with background traffic and random backpressure.
    push_pct = 30; ready_pct = 60;
    for (int f = 0; f < 8; f++) begin
      begin_frame($urandom_range(1, 4)); wait_idle(3000);
      chk("rand_done_cnt", done_cnt, 1);
    end
    push_pct = 0; ready_pct = 100;

`ifdef PE_DRAIN_FULL_PRIO_EN
    // Full FIFO on PE3 jumps ahead of PE0/PE1.
    flush_env(); fill(3, DEPTH); fill(0, 1); fill(1, 1);
    begin_frame(1); run(15);
    chk("prio_order", pack_log(), 64'h301);
    fill(2, 1);
    wait_idle(200);
    chk("prio_done_cnt", done_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
